piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in serial-out serializer; the stage directly upstream of the serial-in serial-out shift register.
//  Accepts a W-bit word over a valid/ready handshake and drives it one bit per clock on so.
//  so connects to the downstream si input; so_valid/done frame the word for monitors and the bench.
// PARAMETERS
//  W          4   data word width in bits; legal range 2..32
//  MSB_FIRST  1   1: bit W-1 shifted out first; 0: bit 0 first
//  IDLE_BIT   0   level driven on so when no bit is being sent
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous, active-high reset
//  data_in     in   W   parallel word, sampled on the accept edge
//  load_valid  in   1   producer has a word on data_in
//  load_ready  out  1   serializer can accept a word this cycle
//  so          out  1   serial data out, registered
//  so_valid    out  1   so carries a word bit this cycle
//  busy        out  1   word in flight (state != IDLE)
//  done        out  1   one-cycle pulse, coincident with the final serial bit
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge): state=IDLE, shreg=0, cnt=0, so=IDLE_BIT, so_valid=0,
//    busy=0, done=0, load_ready=1 from the following cycle. A word in flight is discarded.
//  - All outputs are registered; no combinational path from any input to any output.
//  - FSM states: IDLE, SHIFT, PAR (PAR exists only with PISO_PARITY_EN).
//  - IDLE: load_ready=1, so=IDLE_BIT, so_valid=0. Accept = load_valid & load_ready at an edge:
//    capture data_in into shreg, cnt=0, go to SHIFT. The first bit is on so the cycle after the accept edge.
//  - SHIFT: so=current bit, so_valid=1, load_ready=0, busy=1. Each bit is held exactly one clock.
//    shreg shifts left (MSB_FIRST=1) or right (MSB_FIRST=0); cnt increments each cycle.
//  - cnt is $clog2(W+1) bits wide. The last data bit is the cycle with cnt==W-1; cnt never wraps within a word.
//  - After the last data bit: go to IDLE, or to PAR when parity is enabled.
//  - Latency: accept edge at cycle N; bit i on so in cycle N+1+i.
//    load_ready returns to 1 in cycle N+1+W (N+2+W with parity).
//    Minimum gap between consecutive words is one IDLE cycle.
//  - load_valid while busy: ignored. data_in is not sampled, and load_ready stays 0.
//  - Simultaneous rst and load_valid: rst wins and the word is not accepted.
//  - Changes on data_in after the accept edge have no effect on the word in flight.
// CONFIGURATION
//  PISO_PARITY_EN defined:
//    - After the W data bits, PAR drives one extra bit = ^word (even parity), with so_valid=1.
//    - done pulses on the parity bit, not on the last data bit. Frame length is W+1.
//  PISO_PARITY_EN undefined:
//    - No PAR state; frame length is W.
//    - done pulses on the last data bit.
// TESTING (W=4 unless stated; cycle 1 = first cycle after the accept edge)
//  1. MSB_FIRST=1, load 4'b1011 -> so=1,0,1,1 in cycles 1-4, so_valid=1 in cycles 1-4,
//     done=1 in cycle 4 only, load_ready=1 in cycle 5.
//  2. MSB_FIRST=0, load 4'b1011 -> so=1,1,0,1 in cycles 1-4; so=IDLE_BIT and so_valid=0 in cycle 5.
//  3. PISO_PARITY_EN, MSB_FIRST=1, load 4'b1011 -> so=1,0,1,1 then parity 1 in cycle 5,
//     done in cycle 5 only, load_ready=1 in cycle 6.
//  4. Load 4'b1111, assert rst during cycle 2 -> next cycle: so=0, so_valid=0, busy=0;
//     load_ready=1 the cycle after; no done pulse for the aborted word.
//  5. Hold load_valid=1 with data_in=4'b0110 during an in-flight word -> load_ready stays 0
//     and the word is not accepted. After return to IDLE, 4'b0110 is accepted and shifts out as 0,1,1,0.
//  6. Two words, 4'b1000 then 4'b0001, back to back -> exactly one IDLE cycle between frames;
//     so output matches both words in order.

Source files
------------

// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - handshake and serial-output bundle for piso_serializer
//
// Purpose: groups the parallel load handshake and the framed serial output.
// Signals:
//   data_in    W-bit parallel word from the producer
//   load_valid producer has a word on data_in
//   load_ready serializer can accept a word this cycle
//   so         serial data out
//   so_valid   so carries a word bit this cycle
//   busy       word in flight
//   done       one-cycle pulse on the final serial bit of a frame
// Modports: master = producer / monitor side, slave = serializer side.
interface piso_serializer_if #(
  parameter int W = 4
);
  logic [W-1:0] data_in;
  logic         load_valid;
  logic         load_ready;
  logic         so;
  logic         so_valid;
  logic         busy;
  logic         done;

  modport master (
    output data_in, load_valid,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, so, so_valid, busy, done
  );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out serializer with valid/ready load
//
// Purpose: accepts a W-bit word over a valid/ready handshake and shifts it out
// one bit per clock on so, MSB or LSB first. All outputs are registered.
// Optional feature macro: PISO_PARITY_EN appends one even-parity bit per frame.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  piso_serializer_if.slave (data_in, load_valid in; load_ready, so,
//        so_valid, busy, done out)
// Parameters: W (2..32), MSB_FIRST (1: bit W-1 first), IDLE_BIT (so level when idle).
module piso_serializer #(
  parameter int W         = 4,
  parameter int MSB_FIRST = 1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  piso_serializer_if.slave      bus
);

  localparam int              CW   = $clog2(W + 1);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_PARITY_EN
    , PAR
`endif
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   shreg, shreg_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           so_q, so_n;
  logic           so_valid_q, so_valid_n;
  logic           busy_q, busy_n;
  logic           done_q, done_n;
  logic           ready_q, ready_n;
`ifdef PISO_PARITY_EN
  logic           par_q, par_n;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      so_q       <= IDLE_BIT;
      so_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      cnt        <= cnt_n;
      so_q       <= so_n;
      so_valid_q <= so_valid_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      ready_q    <= ready_n;
`ifdef PISO_PARITY_EN
      par_q      <= par_n;
`endif
    end
  end

  // Next-state logic computes the value each output register will hold in the
  // following cycle, so so/so_valid/done line up with the bit being sent.
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    cnt_n      = cnt;
    so_n       = IDLE_BIT;
    so_valid_n = 1'b0;
    done_n     = 1'b0;
`ifdef PISO_PARITY_EN
    par_n      = par_q;
`endif
    case (state)
      IDLE: begin
        if (bus.load_valid && ready_q) begin
          state_n    = SHIFT;
          shreg_n    = bus.data_in;
          cnt_n      = '0;
          so_n       = (MSB_FIRST != 0) ? bus.data_in[W-1] : bus.data_in[0];
          so_valid_n = 1'b1;
`ifdef PISO_PARITY_EN
          par_n      = ^bus.data_in;
`endif
        end
      end
      SHIFT: begin
        if (cnt == LAST) begin
`ifdef PISO_PARITY_EN
          state_n    = PAR;
          so_n       = par_q;
          so_valid_n = 1'b1;
          done_n     = 1'b1;
`else
          state_n    = IDLE;
`endif
        end else begin
          // so already shows the current bit; present the next one.
          cnt_n      = cnt + CW'(1);
          so_valid_n = 1'b1;
          if (MSB_FIRST != 0) begin
            shreg_n = shreg << 1;
            so_n    = shreg[W-2];
          end else begin
            shreg_n = shreg >> 1;
            so_n    = shreg[1];
          end
`ifndef PISO_PARITY_EN
          done_n     = (cnt == CW'(W - 2));
`endif
        end
      end
`ifdef PISO_PARITY_EN
      PAR: begin
        state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n  = (state_n != IDLE);
    ready_n = (state_n == IDLE);
  end

  assign bus.so         = so_q;
  assign bus.so_valid   = so_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - directed self-checking bench for piso_serializer
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic         load_valid;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.W(W)) ifa ();
  piso_serializer_if #(.W(W)) ifb ();

  assign ifa.data_in    = data_in;
  assign ifa.load_valid = load_valid;
  assign ifb.data_in    = data_in;
  assign ifb.load_valid = load_valid;

  piso_serializer #(.W(W), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_msb (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  piso_serializer #(.W(W), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut_lsb (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word for one accept edge, then scramble data_in.
  task automatic do_load(input logic [W-1:0] d);
    data_in    = d;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    data_in    = 4'b0000;
  endtask

  task automatic test_reset();
    logic [11:0] got;
    rst        = 1'b1;
    load_valid = 1'b1;
    data_in    = 4'b1111;
    tick();
    tick();
    got = {ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready, 1'b0,
           ifb.so, ifb.so_valid, ifb.busy, ifb.done, ifb.load_ready, 1'b0};
    total++;
    if (got !== 12'b000010_000010) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", got, 12'b000010_000010);
    end
    rst        = 1'b0;
    load_valid = 1'b0;
    tick();
    got = {ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready, 1'b0,
           ifb.so, ifb.so_valid, ifb.busy, ifb.done, ifb.load_ready, 1'b0};
    total++;
    if (got !== 12'b000010_000010) begin
      bad++;
      $display("FAIL reset_no_accept: got %b want %b", got, 12'b000010_000010);
    end
  endtask

  // 1011: MSB-first 1,0,1,1; LSB-first 1,1,0,1; parity 1.
  task automatic test_frame_1011();
    logic [7:0] got, exp;
    logic [W-1:0] seq_a = 4'b1011;
    logic [W-1:0] seq_b = 4'b1101;
    do_load(4'b1011);
    for (int c = 1; c <= FL; c++) begin
      got = {ifa.so, ifb.so, ifa.so_valid, ifb.so_valid, ifa.done, ifb.done,
             ifa.busy, ifa.load_ready};
      exp = {(c <= W) ? seq_a[W-c] : 1'b1, (c <= W) ? seq_b[W-c] : 1'b1,
             2'b11, {2{c == FL}}, 1'b1, 1'b0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL frame_1011 cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
    got = {ifa.so, ifb.so, ifa.so_valid, ifb.so_valid, ifa.done, ifb.done,
           ifa.busy, ifa.load_ready};
    total++;
    if (got !== 8'b00000001) begin
      bad++;
      $display("FAIL frame_1011_idle: got %b want %b", got, 8'b00000001);
    end
  endtask

  task automatic test_abort();
    logic [5:0] got;
    int         dones = 0;
    do_load(4'b1111);
    tick();
    rst = 1'b1;
    if (ifa.done || ifb.done) dones++;
    tick();
    rst = 1'b0;
    got = {ifa.so, ifa.so_valid, ifa.busy, ifb.so, ifb.so_valid, ifb.busy};
    total++;
    if (got !== 6'b000000) begin
      bad++;
      $display("FAIL abort_cleared: got %b want %b", got, 6'b000000);
    end
    for (int c = 0; c < 6; c++) begin
      if (ifa.done || ifb.done) dones++;
      tick();
    end
    total++;
    if ({ifa.load_ready, ifb.load_ready} !== 2'b11) begin
      bad++;
      $display("FAIL abort_ready: got %b want %b", {ifa.load_ready, ifb.load_ready}, 2'b11);
    end
    total++;
    if (dones !== 0) begin
      bad++;
      $display("FAIL abort_no_done: got %0d want 0", dones);
    end
  endtask

  // 0011 in flight while 0110 is held valid; 0110 is taken only after IDLE.
  task automatic test_busy_ignore();
    logic [3:0] got, exp;
    logic [W-1:0] seq_a = 4'b0011;
    logic [W-1:0] seq_b = 4'b1100;
    logic [W-1:0] seq_n = 4'b0110;
    do_load(4'b0011);
    data_in    = 4'b0110;
    load_valid = 1'b1;
    for (int c = 1; c <= FL; c++) begin
      got = {ifa.so, ifb.so, ifa.load_ready, ifb.load_ready};
      exp = {(c <= W) ? seq_a[W-c] : 1'b0, (c <= W) ? seq_b[W-c] : 1'b0, 2'b00};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL busy_ignore cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
    total++;
    if ({ifa.load_ready, ifa.so_valid, ifa.busy} !== 3'b100) begin
      bad++;
      $display("FAIL busy_ignore_idle: got %b want %b", {ifa.load_ready, ifa.so_valid, ifa.busy}, 3'b100);
    end
    tick();
    load_valid = 1'b0;
    data_in    = 4'b0000;
    for (int c = 1; c <= FL; c++) begin
      got = {ifa.so, ifb.so, ifa.so_valid, ifb.so_valid};
      exp = {(c <= W) ? seq_n[W-c] : 1'b0, (c <= W) ? seq_n[W-c] : 1'b0, 2'b11};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL late_accept cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
  endtask

  // 1000 then 0001 with the minimum single IDLE cycle between frames.
  task automatic test_back_to_back();
    logic [5:0] got, exp;
    logic [W-1:0] a1 = 4'b1000;
    logic [W-1:0] b1 = 4'b0001;
    logic [W-1:0] a2 = 4'b0001;
    logic [W-1:0] b2 = 4'b1000;
    tick();
    do_load(4'b1000);
    for (int c = 1; c <= FL; c++) begin
      got = {ifa.so, ifb.so, ifa.so_valid, ifb.so_valid, ifa.done, ifb.done};
      exp = {(c <= W) ? a1[W-c] : 1'b1, (c <= W) ? b1[W-c] : 1'b1, 2'b11, {2{c == FL}}};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_first cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
    total++;
    if ({ifa.so_valid, ifb.so_valid, ifa.load_ready, ifb.load_ready} !== 4'b0011) begin
      bad++;
      $display("FAIL b2b_gap: got %b want %b",
               {ifa.so_valid, ifb.so_valid, ifa.load_ready, ifb.load_ready}, 4'b0011);
    end
    do_load(4'b0001);
    for (int c = 1; c <= FL; c++) begin
      got = {ifa.so, ifb.so, ifa.so_valid, ifb.so_valid, ifa.done, ifb.done};
      exp = {(c <= W) ? a2[W-c] : 1'b1, (c <= W) ? b2[W-c] : 1'b1, 2'b11, {2{c == FL}}};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL b2b_second cycle %0d: got %b want %b", c, got, exp);
      end
      tick();
    end
    total++;
    if ({ifa.so_valid, ifa.busy, ifa.load_ready} !== 3'b001) begin
      bad++;
      $display("FAIL b2b_end: got %b want %b", {ifa.so_valid, ifa.busy, ifa.load_ready}, 3'b001);
    end
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    data_in    = '0;
    tick();
    test_reset();
    test_frame_1011();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
